bus_rr_outstanding: RTL and testbench

- Parametrised successor to the simulation system bus: N hosts (core I/D, test utility, DMA-style masters) to M address-mapped devices.
- Adds selectable fixed-priority or round-robin arbitration per device.
- Allows multiple outstanding requests per host, tracked through per-device ordering FIFOs.
- An internal error responder answers unmapped accesses. Used by next-generation ibex_xif simulation tops.

---
 rtl/bus_rr_outstanding.sv | 247 ++++++++++++++++++++++++
 tb/tb_bus_rr_outstanding.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_outstanding.sv
// bus_rr_outstanding
//   Connects NrHosts masters to NrDevices address-mapped slaves. Each device
//   has its own arbiter (fixed priority or round-robin) and an ordering FIFO
//   of granted host IDs, so in-order device responses are routed back to the
//   right host. Hosts may keep up to MaxOutstanding requests in flight, all
//   to a single target at a time. Unmapped accesses are answered one cycle
//   after the grant by an internal error responder (ER).
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   host_*                  per-host request/grant/response, host h at slice h
//   device_*                per-device forwarded request and in-order response
//   cfg_device_addr_base_i  base address per device
//   cfg_device_addr_mask_i  address mask per device
module bus_rr_outstanding #(
  parameter int NrHosts        = 3,
  parameter int NrDevices      = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2,
  parameter int ArbMode        = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,

  input  logic [NrHosts-1:0]                host_req_i,
  output logic [NrHosts-1:0]                host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                host_we_i,
  input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                host_rvalid_o,
  output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                host_err_o,

  output logic [NrDevices-1:0]              device_req_o,
  output logic [NrDevices*AddressWidth-1:0] device_addr_o,
  output logic [NrDevices-1:0]              device_we_o,
  output logic [NrDevices*DataWidth/8-1:0]  device_be_o,
  output logic [NrDevices*DataWidth-1:0]    device_wdata_o,
  input  logic [NrDevices-1:0]              device_rvalid_i,
  input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
  input  logic [NrDevices-1:0]              device_err_i,

  input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
  input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i
);

  localparam int BeWidth = DataWidth / 8;
  localparam int HostW   = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int TgtW    = $clog2(NrDevices + 1);
  localparam int CntW    = $clog2(MaxOutstanding + 1);
  localparam int PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  // Target index NrDevices stands for the error responder.
  localparam logic [TgtW-1:0] TgtEr = TgtW'(NrDevices);

  logic [TgtW-1:0]  tgt          [NrHosts];
  logic [NrHosts-1:0] eligible;
  logic [NrHosts-1:0] host_gnt;
  logic [NrHosts-1:0] host_rvalid;

  logic [CntW-1:0]  outstanding_q [NrHosts];
  logic [TgtW-1:0]  last_tgt_q    [NrHosts];
  logic [NrHosts-1:0] er_pending_q;

  logic [HostW-1:0] fifo_mem_q [NrDevices][MaxOutstanding];
  logic [PtrW-1:0]  fifo_wr_q  [NrDevices];
  logic [PtrW-1:0]  fifo_rd_q  [NrDevices];
  logic [CntW-1:0]  fifo_cnt_q [NrDevices];
  logic [HostW-1:0] rr_ptr_q   [NrDevices];
  // Set once a device has been granted since reset; responses to requests
  // issued before a reset are expected and silently dropped until then.
  logic [NrDevices-1:0] seen_grant_q;

  logic [NrDevices-1:0] dev_gnt;
  logic [HostW-1:0]     dev_winner [NrDevices];
  logic [NrDevices-1:0] dev_pop;
  logic [HostW-1:0]     dev_head   [NrDevices];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // Address decode: iterate downwards so the lowest matching device wins.
  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      tgt[h] = TgtEr;
      for (int d = NrDevices - 1; d >= 0; d--) begin
        if ((host_addr_i[h*AddressWidth +: AddressWidth] &
             cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth]) ==
            cfg_device_addr_base_i[d*AddressWidth +: AddressWidth]) begin
          tgt[h] = TgtW'(d);
        end
      end
    end
  end

  // A host with requests in flight may only continue to the same target,
  // otherwise responses from two devices could return out of order.
  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      eligible[h] = !rst_i && host_req_i[h] &&
                    (outstanding_q[h] < CntW'(MaxOutstanding)) &&
                    ((outstanding_q[h] == '0) || (tgt[h] == last_tgt_q[h]));
    end
  end

  // Per-device arbitration and request forwarding. FIFO fullness is taken
  // from the registered count, i.e. before any pop in this cycle.
  always_comb begin
    logic [HostW-1:0] idx;
    idx            = '0;
    dev_gnt        = '0;
    host_gnt       = '0;
    device_req_o   = '0;
    device_addr_o  = '0;
    device_we_o    = '0;
    device_be_o    = '0;
    device_wdata_o = '0;
    for (int d = 0; d < NrDevices; d++) begin
      dev_winner[d] = '0;
      if (fifo_cnt_q[d] != CntW'(MaxOutstanding)) begin
        for (int i = 0; i < NrHosts; i++) begin
          if (ArbMode == 1) begin
            idx = HostW'((int'(rr_ptr_q[d]) + i) % NrHosts);
          end else begin
            idx = HostW'(i);
          end
          if (!dev_gnt[d] && eligible[idx] && (tgt[idx] == TgtW'(d))) begin
            dev_gnt[d]    = 1'b1;
            dev_winner[d] = idx;
          end
        end
      end
      if (dev_gnt[d]) begin
        host_gnt[dev_winner[d]] = 1'b1;
        device_req_o[d]         = 1'b1;
        device_addr_o[d*AddressWidth +: AddressWidth] =
          host_addr_i[dev_winner[d]*AddressWidth +: AddressWidth];
        device_we_o[d] = host_we_i[dev_winner[d]];
        device_be_o[d*BeWidth +: BeWidth] =
          host_be_i[dev_winner[d]*BeWidth +: BeWidth];
        device_wdata_o[d*DataWidth +: DataWidth] =
          host_wdata_i[dev_winner[d]*DataWidth +: DataWidth];
      end
    end
    // The error responder accepts every eligible unmapped request at once.
    for (int h = 0; h < NrHosts; h++) begin
      if (eligible[h] && (tgt[h] == TgtEr)) begin
        host_gnt[h] = 1'b1;
      end
    end
  end

  assign host_gnt_o = host_gnt;

  // Response routing: the FIFO head names the host that owns the response.
  always_comb begin
    host_rvalid  = '0;
    host_err_o   = '0;
    host_rdata_o = '0;
    dev_pop      = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (er_pending_q[h]) begin
        host_rvalid[h] = 1'b1;
        host_err_o[h]  = 1'b1;
      end
    end
    for (int d = 0; d < NrDevices; d++) begin
      dev_head[d] = fifo_mem_q[d][fifo_rd_q[d]];
      dev_pop[d]  = !rst_i && device_rvalid_i[d] && (fifo_cnt_q[d] != '0);
      if (dev_pop[d]) begin
        host_rvalid[dev_head[d]] = 1'b1;
        host_err_o[dev_head[d]]  = device_err_i[d];
        host_rdata_o[dev_head[d]*DataWidth +: DataWidth] =
          device_rdata_i[d*DataWidth +: DataWidth];
      end
    end
  end

  assign host_rvalid_o = host_rvalid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      er_pending_q <= '0;
      seen_grant_q <= '0;
      for (int h = 0; h < NrHosts; h++) begin
        outstanding_q[h] <= '0;
        last_tgt_q[h]    <= '0;
      end
      for (int d = 0; d < NrDevices; d++) begin
        fifo_wr_q[d]  <= '0;
        fifo_rd_q[d]  <= '0;
        fifo_cnt_q[d] <= '0;
        rr_ptr_q[d]   <= '0;
        for (int e = 0; e < MaxOutstanding; e++) begin
          fifo_mem_q[d][e] <= '0;
        end
      end
    end else begin
      for (int h = 0; h < NrHosts; h++) begin
        er_pending_q[h] <= host_gnt[h] && (tgt[h] == TgtEr);
        if (host_gnt[h]) begin
          last_tgt_q[h] <= tgt[h];
        end
        // Grant and response in the same cycle leave the count unchanged.
        if (host_gnt[h] && !host_rvalid[h]) begin
          if (outstanding_q[h] != CntW'(MaxOutstanding)) begin
            outstanding_q[h] <= outstanding_q[h] + 1'b1;
          end
        end else if (!host_gnt[h] && host_rvalid[h]) begin
          if (outstanding_q[h] != '0) begin
            outstanding_q[h] <= outstanding_q[h] - 1'b1;
          end
        end
      end
      for (int d = 0; d < NrDevices; d++) begin
        if (dev_gnt[d]) begin
          fifo_mem_q[d][fifo_wr_q[d]] <= dev_winner[d];
          fifo_wr_q[d]                <= ptr_inc(fifo_wr_q[d]);
          seen_grant_q[d]             <= 1'b1;
          if (ArbMode == 1) begin
            rr_ptr_q[d] <= (dev_winner[d] == HostW'(NrHosts - 1)) ?
                           '0 : dev_winner[d] + 1'b1;
          end
        end
        if (dev_pop[d]) begin
          fifo_rd_q[d] <= ptr_inc(fifo_rd_q[d]);
        end
        case ({dev_gnt[d], dev_pop[d]})
          2'b10:   fifo_cnt_q[d] <= fifo_cnt_q[d] + 1'b1;
          2'b01:   fifo_cnt_q[d] <= fifo_cnt_q[d] - 1'b1;
          default: fifo_cnt_q[d] <= fifo_cnt_q[d];
        endcase
      end
    end
  end

  // A response with nothing outstanding on that device points at a
  // misbehaving device model.
  for (genvar d = 0; d < NrDevices; d++) begin : g_rsp_chk
    a_rvalid_with_pending: assert property (@(posedge clk_i) disable iff (rst_i)
      !(device_rvalid_i[d] && seen_grant_q[d] && (fifo_cnt_q[d] == '0)));
  end

endmodule

// File: tb/tb_bus_rr_outstanding.sv
module tb_bus_rr_outstanding;

  localparam logic [31:0] A  = 32'h0000_0100;
  localparam logic [31:0] B  = 32'h0002_0010;
  localparam logic [31:0] U  = 32'h4000_0000;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] W0 = 32'hD000_0000;
  localparam logic [31:0] W1 = 32'hD000_0001;
  localparam logic [31:0] W2 = 32'hD000_0002;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [95:0] haddr;
  logic [2:0]  hwe;
  logic [11:0] hbe;
  logic [95:0] hwdata;
  logic [1:0]  drv;
  logic [63:0] drdata;
  logic [1:0]  derr;
  logic [63:0] cbase;
  logic [63:0] cmask;

  logic [2:0]  fx_gnt, fx_rv, fx_err;
  logic [95:0] fx_rdata;
  logic [1:0]  fx_dreq, fx_dwe;
  logic [63:0] fx_daddr, fx_dwd;
  logic [7:0]  fx_dbe;

  logic [2:0]  rr_gnt, rr_rv, rr_err;
  logic [95:0] rr_rdata;
  logic [1:0]  rr_dreq, rr_dwe;
  logic [63:0] rr_daddr, rr_dwd;
  logic [7:0]  rr_dbe;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_rr_outstanding #(.ArbMode(0)) u_fix (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(req), .host_gnt_o(fx_gnt), .host_addr_i(haddr),
    .host_we_i(hwe), .host_be_i(hbe), .host_wdata_i(hwdata),
    .host_rvalid_o(fx_rv), .host_rdata_o(fx_rdata), .host_err_o(fx_err),
    .device_req_o(fx_dreq), .device_addr_o(fx_daddr), .device_we_o(fx_dwe),
    .device_be_o(fx_dbe), .device_wdata_o(fx_dwd),
    .device_rvalid_i(drv), .device_rdata_i(drdata), .device_err_i(derr),
    .cfg_device_addr_base_i(cbase), .cfg_device_addr_mask_i(cmask)
  );

  bus_rr_outstanding #(.ArbMode(1)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(req), .host_gnt_o(rr_gnt), .host_addr_i(haddr),
    .host_we_i(hwe), .host_be_i(hbe), .host_wdata_i(hwdata),
    .host_rvalid_o(rr_rv), .host_rdata_o(rr_rdata), .host_err_o(rr_err),
    .device_req_o(rr_dreq), .device_addr_o(rr_daddr), .device_we_o(rr_dwe),
    .device_be_o(rr_dbe), .device_wdata_o(rr_dwd),
    .device_rvalid_i(drv), .device_rdata_i(drdata), .device_err_i(derr),
    .cfg_device_addr_base_i(cbase), .cfg_device_addr_mask_i(cmask)
  );

  typedef struct {
    logic [2:0]  req;
    logic [31:0] a0, a1, a2;
    logic [1:0]  drv;
    logic [31:0] rd0, rd1;
    logic [1:0]  derr;
    logic [2:0]  gnt;
    logic [1:0]  dreq;
    logic [63:0] daddr;
    logic [63:0] dwd;
    logic [1:0]  dwe;
    logic [2:0]  rv;
    logic [2:0]  err;
    logic [95:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [2:0] req_v, input logic [31:0] a0, a1, a2,
    input logic [1:0] drv_v, input logic [31:0] rd0, rd1, input logic [1:0] derr_v,
    input logic [2:0] gnt, input logic [1:0] dreq, input logic [63:0] daddr, dwd,
    input logic [1:0] dwe, input logic [2:0] rv, err, input logic [95:0] rdata);
    vec_t v;
    v.req = req_v; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.drv = drv_v; v.rd0 = rd0; v.rd1 = rd1; v.derr = derr_v;
    v.gnt = gnt; v.dreq = dreq; v.daddr = daddr; v.dwd = dwd; v.dwe = dwe;
    v.rv = rv; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  exp_g, exp_rv;
    logic [95:0] exp_rd;
    int          rv_cnt0, rv_cnt2;

    cbase  = {32'h0002_0000, 32'h0000_0000};
    cmask  = {32'hFFFF_FC00, 32'hFFFF_0000};
    hwe    = 3'b100;
    hbe    = {4'hF, 4'h3, 4'h1};
    hwdata = {W2, W1, W0};
    drv    = 2'b00;
    drdata = '0;
    derr   = 2'b00;
    rst    = 1'b1;
    req    = 3'b111;
    haddr  = {A, A, A};

    // idle, 3-way contention, full FIFO, push+pop, error response
    vecs.push_back(mk(3'b000, A, A, A, 2'b00, Z, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b111, A, A, A, 2'b00, Z, Z, 2'b00, 3'b001, 2'b01, {Z, A}, {Z, W0}, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b110, A, A, A, 2'b00, Z, Z, 2'b00, 3'b010, 2'b01, {Z, A}, {Z, W1}, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b100, A, A, A, 2'b01, 32'hAAAA_0000, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b001, 3'b000, {Z, Z, 32'hAAAA_0000}));
    vecs.push_back(mk(3'b100, A, A, A, 2'b01, 32'hBBBB_1111, Z, 2'b00, 3'b100, 2'b01, {Z, A}, {Z, W2}, 2'b01, 3'b010, 3'b000, {Z, 32'hBBBB_1111, Z}));
    vecs.push_back(mk(3'b000, A, A, A, 2'b01, 32'hCCCC_2222, Z, 2'b01, 3'b000, 2'b00, '0, '0, 2'b00, 3'b100, 3'b100, {32'hCCCC_2222, Z, Z}));
    vecs.push_back(mk(3'b000, A, A, A, 2'b00, Z, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b000, 3'b000, '0));
    // unmapped access
    vecs.push_back(mk(3'b010, A, U, A, 2'b00, Z, Z, 2'b00, 3'b010, 2'b00, '0, '0, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b000, A, U, A, 2'b00, Z, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b010, 3'b010, '0));
    vecs.push_back(mk(3'b000, A, U, A, 2'b00, Z, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b000, 3'b000, '0));
    // outstanding limit on dev1, response 5 cycles after first grant
    vecs.push_back(mk(3'b010, A, B, A, 2'b00, Z, Z, 2'b00, 3'b010, 2'b10, {B, Z}, {W1, Z}, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b010, A, B, A, 2'b00, Z, Z, 2'b00, 3'b010, 2'b10, {B, Z}, {W1, Z}, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b010, A, B, A, 2'b00, Z, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b010, A, B, A, 2'b00, Z, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b010, A, B, A, 2'b00, Z, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b010, A, B, A, 2'b10, Z, 32'h1111_2222, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b010, 3'b000, {Z, 32'h1111_2222, Z}));
    vecs.push_back(mk(3'b010, A, B, A, 2'b00, Z, Z, 2'b00, 3'b010, 2'b10, {B, Z}, {W1, Z}, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b000, A, B, A, 2'b10, Z, 32'h3333_4444, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b010, 3'b000, {Z, 32'h3333_4444, Z}));
    vecs.push_back(mk(3'b000, A, B, A, 2'b10, Z, 32'h5555_6666, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b010, 3'b000, {Z, 32'h5555_6666, Z}));
    vecs.push_back(mk(3'b000, A, B, A, 2'b00, Z, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b000, 3'b000, '0));
    // cross-device block
    vecs.push_back(mk(3'b001, A, A, A, 2'b00, Z, Z, 2'b00, 3'b001, 2'b01, {Z, A}, {Z, W0}, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b001, B, A, A, 2'b00, Z, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b001, B, A, A, 2'b00, Z, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b001, B, A, A, 2'b01, 32'h7777_8888, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b001, 3'b000, {Z, Z, 32'h7777_8888}));
    vecs.push_back(mk(3'b001, B, A, A, 2'b00, Z, Z, 2'b00, 3'b001, 2'b10, {B, Z}, {W0, Z}, 2'b00, 3'b000, 3'b000, '0));
    vecs.push_back(mk(3'b000, B, A, A, 2'b10, Z, 32'h9999_AAAA, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b001, 3'b000, {Z, Z, 32'h9999_AAAA}));
    vecs.push_back(mk(3'b000, B, A, A, 2'b00, Z, Z, 2'b00, 3'b000, 2'b00, '0, '0, 2'b00, 3'b000, 3'b000, '0));

    // outputs held at zero during reset even with live requests
    #2;
    chk("reset gnt", {125'b0, fx_gnt}, 128'h0);
    chk("reset dreq", {126'b0, fx_dreq}, 128'h0);
    chk("reset rvalid", {125'b0, fx_rv}, 128'h0);
    chk("reset rr gnt", {125'b0, rr_gnt}, 128'h0);
    cyc();
    cyc();
    rst = 1'b0;
    req = 3'b000;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc();
      req    = vecs[i].req;
      haddr  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      drv    = vecs[i].drv;
      drdata = {vecs[i].rd1, vecs[i].rd0};
      derr   = vecs[i].derr;
      #3;
      chk($sformatf("v%0d gnt", i), {125'b0, fx_gnt}, {125'b0, vecs[i].gnt});
      chk($sformatf("v%0d dreq", i), {126'b0, fx_dreq}, {126'b0, vecs[i].dreq});
      chk($sformatf("v%0d daddr", i), {64'b0, fx_daddr}, {64'b0, vecs[i].daddr});
      chk($sformatf("v%0d dwdata", i), {64'b0, fx_dwd}, {64'b0, vecs[i].dwd});
      chk($sformatf("v%0d dwe", i), {126'b0, fx_dwe}, {126'b0, vecs[i].dwe});
      chk($sformatf("v%0d rvalid", i), {125'b0, fx_rv}, {125'b0, vecs[i].rv});
      chk($sformatf("v%0d err", i), {125'b0, fx_err}, {125'b0, vecs[i].err});
      chk($sformatf("v%0d rdata", i), {32'b0, fx_rdata}, {32'b0, vecs[i].rdata});
    end

    // reset with two requests in flight on dev0
    cyc();
    req = 3'b001; haddr = {A, A, A}; drv = 2'b00; derr = 2'b00;
    #3;
    chk("mid 1st gnt", {125'b0, fx_gnt}, {125'b0, 3'b001});
    cyc();
    #3;
    chk("mid 2nd gnt", {125'b0, fx_gnt}, {125'b0, 3'b001});
    cyc();
    rst = 1'b1;
    drv = 2'b01; drdata = {Z, 32'hDEAD_BEEF};
    #1;
    chk("mid rst gnt", {125'b0, fx_gnt}, 128'h0);
    chk("mid rst dreq", {126'b0, fx_dreq}, 128'h0);
    chk("mid rst rvalid", {125'b0, fx_rv}, 128'h0);
    chk("mid rst rr gnt", {125'b0, rr_gnt}, 128'h0);
    cyc();
    cyc();
    rst = 1'b0; req = 3'b000; drv = 2'b00;
    cyc();
    drv = 2'b01;
    #3;
    chk("stale rvalid", {125'b0, fx_rv}, 128'h0);
    cyc();
    drv = 2'b00; req = 3'b001;
    #3;
    chk("post rst gnt1", {125'b0, fx_gnt}, {125'b0, 3'b001});
    cyc();
    #3;
    chk("post rst gnt2", {125'b0, fx_gnt}, {125'b0, 3'b001});
    cyc();
    req = 3'b000; drv = 2'b01; drdata = {Z, 32'h0123_4567};
    #3;
    chk("post rst rsp1", {125'b0, fx_rv}, {125'b0, 3'b001});
    chk("post rst rdata1", {32'b0, fx_rdata}, {32'b0, Z, Z, 32'h0123_4567});
    cyc();
    drdata = {Z, 32'h89AB_CDEF};
    #3;
    chk("post rst rsp2", {125'b0, fx_rv}, {125'b0, 3'b001});
    cyc();
    drv = 2'b00;
    #3;
    chk("post rst idle", {125'b0, fx_rv}, 128'h0);

    // round-robin on dev1: hosts 0 and 2, device answers one cycle later
    rv_cnt0 = 0;
    rv_cnt2 = 0;
    for (int c = 0; c < 7; c++) begin
      cyc();
      req    = (c < 6) ? 3'b101 : 3'b000;
      haddr  = {B, B, B};
      drv    = (c >= 1) ? 2'b10 : 2'b00;
      drdata = {32'h1000 + 32'(c), Z};
      #3;
      exp_g  = (c < 6) ? ((c % 2 == 0) ? 3'b001 : 3'b100) : 3'b000;
      exp_rv = (c == 0) ? 3'b000 : (((c - 1) % 2 == 0) ? 3'b001 : 3'b100);
      exp_rd = '0;
      if (exp_rv[0]) exp_rd[31:0]  = 32'h1000 + 32'(c);
      if (exp_rv[2]) exp_rd[95:64] = 32'h1000 + 32'(c);
      chk($sformatf("rr c%0d gnt", c), {125'b0, rr_gnt}, {125'b0, exp_g});
      chk($sformatf("rr c%0d rvalid", c), {125'b0, rr_rv}, {125'b0, exp_rv});
      chk($sformatf("rr c%0d rdata", c), {32'b0, rr_rdata}, {32'b0, exp_rd});
      chk($sformatf("rr c%0d fixed gnt", c), {125'b0, fx_gnt}, {125'b0, (c < 6) ? 3'b001 : 3'b000});
      if (rr_rv[0]) rv_cnt0++;
      if (rr_rv[2]) rv_cnt2++;
    end
    cyc();
    drv = 2'b00;
    #3;
    chk("rr host0 rsp count", 128'(rv_cnt0), 128'd3);
    chk("rr host2 rsp count", 128'(rv_cnt2), 128'd3);
    chk("rr idle rvalid", {125'b0, rr_rv}, 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
